// File: rtl/led_pwm_fader.sv
// LED PWM fader: NUM_LEDS registered PWM outputs whose duties change only at
// period boundaries, with an optional triangular "breathing" brightness envelope.
module led_pwm_fader #(
  parameter int NUM_LEDS = 5,
  parameter int PRESCALE = 1024,
  parameter int STEP     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                duty_valid,
  output logic                duty_ready,
  input  logic [2:0]          duty_idx,
  input  logic [7:0]          duty_data,
  input  logic                mode_breathe,
  output logic [NUM_LEDS-1:0] led,
  output logic                period_pulse
);

  localparam int              PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
  localparam logic [7:0]      STEP_B = 8'(STEP);
  localparam logic [3:0]      NUM_B  = 4'(NUM_LEDS);

  typedef enum logic [1:0] {ST_STATIC, ST_RISE, ST_FALL} state_t;

  logic [PS_W-1:0] prescaler;
  logic [7:0]      pwm_cnt;
  logic            tick;
  logic            boundary;

  logic            slot_full;
  logic [2:0]      slot_idx;
  logic [7:0]      slot_data;
  logic            slot_fill;
  logic            commit;

  logic [7:0]      active_duty [NUM_LEDS];
  logic [7:0]      eff_duty    [NUM_LEDS];

  state_t          state, state_next;
  logic [7:0]      level, level_next;
  logic [8:0]      level_up;

  assign tick         = (prescaler == PS_MAX);
  assign boundary     = tick && (pwm_cnt == 8'hFF);
  assign period_pulse = boundary;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PS_W'(1);
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Single-entry shadow slot; out-of-range channel writes are accepted and dropped.
  assign slot_fill = duty_valid && duty_ready && ({1'b0, duty_idx} < NUM_B);
  assign commit    = boundary && slot_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full  <= 1'b0;
      slot_idx   <= '0;
      slot_data  <= '0;
      duty_ready <= 1'b0;
    end else begin
      if (commit) begin
        slot_full <= 1'b0;
      end else if (slot_fill) begin
        slot_full <= 1'b1;
        slot_idx  <= duty_idx;
        slot_data <= duty_data;
      end
      duty_ready <= !((slot_full && !commit) || slot_fill);
    end
  end

  // NOTE: active_duty is reset explicitly so the LEDs come up dark, never random.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LEDS; i++) active_duty[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++)
        if (commit && (slot_idx == 3'(i))) active_duty[i] <= slot_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_STATIC;
      level <= 8'hFF;
    end else begin
      state <= state_next;
      level <= level_next;
    end
  end

  assign level_up = {1'b0, level} + {1'b0, STEP_B};

  // NOTE: defaults first so no path leaves state_next/level_next unassigned (no latch).
  always_comb begin
    state_next = state;
    level_next = level;
    if (boundary) begin
      unique case (state)
        ST_STATIC: begin
          if (mode_breathe) begin
            state_next = ST_RISE;
            level_next = 8'h00;
          end else begin
            level_next = 8'hFF;
          end
        end
        ST_RISE: begin
          if (!mode_breathe) begin
            state_next = ST_STATIC;
            level_next = 8'hFF;
          end else if (level_up > 9'd255) begin
            state_next = ST_FALL;
            level_next = 8'hFF;
          end else begin
            level_next = level_up[7:0];
          end
        end
        ST_FALL: begin
          if (!mode_breathe) begin
            state_next = ST_STATIC;
            level_next = 8'hFF;
          end else if (level < STEP_B) begin
            state_next = ST_RISE;
            level_next = 8'h00;
          end else begin
            level_next = level - STEP_B;
          end
        end
        default: begin
          state_next = ST_STATIC;
          level_next = 8'hFF;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++)
      eff_duty[i] = (state == ST_STATIC) ? active_duty[i]
                  : 8'((16'(active_duty[i]) * 16'(level)) >> 8);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) led[i] <= (eff_duty[i] > pwm_cnt);
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader: per-period LED on-counts, handshake and
// strobe timing are compared against a period-level behavioural model.
module tb_led_pwm_fader;

  localparam int NUM_LEDS = 5;
  localparam int PRESCALE = 1;
  localparam int STEP     = 64;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                duty_valid = 1'b0;
  logic                duty_ready;
  logic [2:0]          duty_idx = '0;
  logic [7:0]          duty_data = '0;
  logic                mode_breathe = 1'b0;
  logic [NUM_LEDS-1:0] led;
  logic                period_pulse;

  int checks = 0;
  int failures = 0;

  // Period-level model: duties in force, pending slot, envelope level and direction.
  int m_active [NUM_LEDS];
  int m_level;
  int m_dir;
  bit m_pend;
  int m_pidx;
  int m_pdata;

  led_pwm_fader #(.NUM_LEDS(NUM_LEDS), .PRESCALE(PRESCALE), .STEP(STEP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .duty_idx     (duty_idx),
    .duty_data    (duty_data),
    .mode_breathe (mode_breathe),
    .led          (led),
    .period_pulse (period_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_LEDS; i++) m_active[i] = 0;
    m_level = 255;
    m_dir   = 0;
    m_pend  = 0;
  endtask

  function automatic int model_eff(input int i);
    return (m_dir == 0) ? m_active[i] : (m_active[i] * m_level) / 256;
  endfunction

  task automatic model_boundary(input bit mode);
    if (m_pend) begin
      m_active[m_pidx] = m_pdata;
      m_pend = 0;
    end
    if (m_dir == 0) begin
      if (mode) begin m_dir = 1; m_level = 0; end
    end else if (!mode) begin
      m_dir = 0; m_level = 255;
    end else if (m_dir > 0) begin
      if (m_level + STEP > 255) begin m_level = 255; m_dir = -1; end
      else m_level += STEP;
    end else begin
      if (m_level < STEP) begin m_level = 0; m_dir = 1; end
      else m_level -= STEP;
    end
  endtask

  // Waits for a strobe, returns the negedges counted, ends one cycle past it.
  task automatic sync(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_pulse && n < 600);
    check("sync_pulse", period_pulse, 1);
    @(negedge clk);
  endtask

  // Runs one PWM period starting at its first cycle; optional write and mode.
  task automatic step_period(input bit wr, input int idx, input int data, input bit mode,
                             input bit keep_valid, input int exp0, input string tag);
    int cnt [NUM_LEDS];
    int exp_cnt [NUM_LEDS];
    int rdy_hi, pulses, pulse_pos;
    bit fill;
    rdy_hi = 0; pulses = 0; pulse_pos = -1;
    for (int i = 0; i < NUM_LEDS; i++) begin
      cnt[i] = 0;
      exp_cnt[i] = model_eff(i);
    end
    if (exp0 >= 0) exp_cnt[0] = exp0;
    fill = wr && (idx < NUM_LEDS);
    mode_breathe = mode;
    if (wr) begin
      check({tag, "_ready_pre"}, duty_ready, 1);
      duty_valid = 1'b1;
      duty_idx   = 3'(idx);
      duty_data  = 8'(data);
    end
    for (int j = 0; j < 256; j++) begin
      @(negedge clk);
      if (j == 0) begin
        if (keep_valid) duty_data = 8'($urandom);
        else duty_valid = 1'b0;
      end
      for (int i = 0; i < NUM_LEDS; i++) cnt[i] += int'(led[i]);
      rdy_hi += int'(duty_ready);
      if (period_pulse) begin
        pulses++;
        pulse_pos = j;
      end
    end
    for (int i = 0; i < NUM_LEDS; i++)
      check($sformatf("%s_led%0d_on", tag, i), cnt[i], exp_cnt[i]);
    check({tag, "_ready_high_cycles"}, rdy_hi, fill ? 1 : 256);
    check({tag, "_pulse_count"}, pulses, 1);
    check({tag, "_pulse_pos"}, pulse_pos, 254);
    if (fill) begin
      m_pend  = 1;
      m_pidx  = idx;
      m_pdata = data;
    end
    model_boundary(mode);
  endtask

  initial begin
    int n;
    int lvl_tab [10];
    bit mode;
    lvl_tab = '{0, 64, 128, 192, 255, 191, 127, 63, 0, 64};

    // Reset is visible without any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("reset_led", led, 0);
    check("reset_ready", duty_ready, 0);
    check("reset_pulse", period_pulse, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("release_ready_before_edge", duty_ready, 0);
    @(posedge clk);
    #1 check("release_ready_first_edge", duty_ready, 1);
    sync(n);
    check("start_first_pulse_delay", n, 255);
    model_reset();

    // Basic write, then an out-of-range write that must be discarded.
    step_period(1, 2, 64, 0, 0, -1, "w2_issue");
    step_period(1, 7, 200, 0, 0, -1, "w7_discard");
    step_period(0, 0, 0, 0, 0, -1, "w2_steady");

    // Reset mid-period with a write still pending in the slot.
    duty_valid = 1'b1;
    duty_idx   = 3'd1;
    duty_data  = 8'd153;
    check("rst_ready_pre", duty_ready, 1);
    @(negedge clk);
    duty_valid = 1'b0;
    check("rst_slot_full_ready", duty_ready, 0);
    repeat (48) @(negedge clk);
    check("pre_reset_led", led, 5'b00100);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_led", led, 0);
    check("mid_reset_ready", duty_ready, 0);
    check("mid_reset_pulse", period_pulse, 0);
    repeat (3) @(negedge clk);
    check("held_reset_led", led, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("rerelease_ready_first_edge", duty_ready, 1);
    sync(n);
    check("restart_first_pulse_delay", n, 255);
    model_reset();
    step_period(0, 0, 0, 0, 0, -1, "post_reset_a");
    step_period(0, 0, 0, 0, 0, -1, "post_reset_b");

    // Back-to-back writes with duty_valid held high.
    step_period(1, 0, $urandom_range(0, 255), 0, 1, -1, "b2b_0");
    step_period(1, 1, $urandom_range(0, 255), 0, 1, -1, "b2b_1");
    step_period(1, 3, $urandom_range(0, 255), 0, 1, -1, "b2b_2");
    step_period(1, 4, $urandom_range(0, 255), 0, 0, -1, "b2b_3");
    step_period(0, 0, 0, 0, 0, -1, "b2b_done");

    // Breathing envelope on a full-scale channel 0.
    step_period(1, 0, 255, 0, 0, -1, "br_load");
    step_period(0, 0, 0, 1, 0, 255, "br_start");
    for (int k = 0; k < 10; k++)
      step_period(0, 0, 0, 1, 0, (255 * lvl_tab[k]) / 256, $sformatf("br_lvl%0d", k));
    step_period(0, 0, 0, 1, 0, -1, "br_rise128");
    step_period(0, 0, 0, 1, 0, -1, "br_rise192");
    step_period(0, 0, 0, 1, 0, -1, "br_top");
    step_period(0, 0, 0, 0, 0, (255 * 191) / 256, "br_drop_in_fall");
    step_period(0, 0, 0, 0, 0, 255, "br_static_again");

    // Randomised writes and mode changes.
    mode = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 4) == 0) mode = ~mode;
      step_period(bit'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 255),
                  mode, 0, -1, $sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pwm_fader.md
LED_PWM_FADER -- requirements
Module: led_pwm_fader

Interface
REQ-001 Parameter NUM_LEDS, default 5: number of LED channels driven.
REQ-002 Parameter PRESCALE, default 1024: clk cycles per PWM step (min 1).
REQ-003 Parameter STEP, default 4: breathe-level increment per PWM period (1..255).
REQ-004 Port clk  input  1  single system clock, taken from the global buffer output; all logic on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port duty_valid  input  1  duty write request.
REQ-007 Port duty_ready  output  1  block can accept a duty write.
REQ-008 Port duty_idx  input  3  target channel of the write.
REQ-009 Port duty_data  input  8  new duty value, 0..255.
REQ-010 Port mode_breathe  input  1  1 = breathing modulation requested, 0 = static.
REQ-011 Port led  output  NUM_LEDS  registered PWM output per channel, active-high.
REQ-012 Port period_pulse  output  1  one-cycle strobe at each PWM period boundary.

Function
REQ-013 The prescaler SHALL count 0..PRESCALE-1 and wrap; tick = prescaler at PRESCALE-1.
REQ-014 The 8-bit pwm_cnt SHALL increment on tick only and wrap 255->0.
REQ-015 The period boundary SHALL be the tick on which pwm_cnt goes 255->0; period_pulse SHALL be high for exactly that one cycle.
REQ-016 A write SHALL transfer on a rising edge with duty_valid=1 and duty_ready=1; duty_idx and duty_data SHALL be sampled at that edge only.
REQ-017 A transfer with duty_idx < NUM_LEDS SHALL fill a single shadow slot (idx, data), and duty_ready SHALL go low the next cycle.
REQ-018 A transfer with duty_idx >= NUM_LEDS SHALL be accepted and discarded, with duty_ready staying high.
REQ-019 A full shadow slot SHALL be copied to active_duty[idx] on the period-boundary cycle, and duty_ready SHALL return high in the following cycle.
REQ-020 Active duties SHALL change only at period boundaries, so no partial or glitched period is produced.
REQ-021 The breathe FSM SHALL have states STATIC, RISE and FALL, with an 8-bit level register, and SHALL evaluate only on period-boundary cycles.
REQ-022 STATIC: level=255; if mode_breathe=1 -> RISE with level=0.
REQ-023 RISE: if level+STEP > 255 -> level=255, FALL; else level+=STEP.
REQ-024 FALL: if level < STEP -> level=0, RISE; else level-=STEP.
REQ-025 In RISE or FALL, if mode_breathe=0 at a boundary -> STATIC with level=255; this check takes priority over the stepping rules.
REQ-026 Effective duty SHALL be active_duty in STATIC, and (active_duty*level)>>8 (16-bit product, truncated) in RISE/FALL.
REQ-027 led[i] SHALL be registered: led[i] <= (eff_duty[i] > pwm_cnt), giving one cycle of latency from the pwm_cnt value.
REQ-028 Duty 0 SHALL keep the LED always off; duty 255 in STATIC SHALL light it for 255 of 256 steps.
REQ-029 A commit and an FSM level update on the same boundary SHALL both take effect for the next period.

Reset
REQ-030 While rst_n=0, all of the following SHALL hold immediately, without a clock: prescaler=0, pwm_cnt=0, all active_duty=0, shadow slot empty, state=STATIC, level=255, led=0, period_pulse=0, duty_ready=0.
REQ-031 duty_ready SHALL go to 1 on the first rising clk edge after rst_n deasserts.
REQ-032 A reset during a pending write SHALL discard the shadow slot with no commit.
REQ-033 A reset mid-period SHALL restart the PWM at pwm_cnt=0 on release.

Verification
REQ-034 PRESCALE=1: write idx=2, data=64 -> duty_ready low until boundary; after commit, led[2] high for exactly 64 of every 256 cycles; other LEDs stay 0.
REQ-035 Write idx=7, data=200 -> accepted, duty_ready stays 1, no LED changes, no slot fill.
REQ-036 Hold duty_valid=1 with back-to-back writes -> exactly one transfer per PWM period; values commit in order; none lost.
REQ-037 duty[0]=255, STEP=64, mode_breathe=1 -> level over successive periods is 0,64,128,192,255,191,127,63,0,64; led[0] on-count per period equals (255*level)>>8.
REQ-038 Drop mode_breathe in FALL -> STATIC with level=255 at the next boundary; led[0] on-count returns to 255.
REQ-039 Assert rst_n=0 mid-period with a pending write -> led=0 and duty_ready=0 asynchronously; after release, duty_ready=1 on the first edge, all duties are 0, and the pending value never appears.
